// File: rtl/lvds_frame_rx.sv
// LVDS sensor frame receiver: reset sequencer, line/frame tagger and
// show-ahead AXI-Stream output FIFO with overflow accounting.
module lvds_frame_rx #(
  parameter int DW       = 15,
  parameter int GW       = 1,
  parameter int LINE_LEN = 640,
  parameter int FIFO_AW  = 4,
  parameter int T_RSTA   = 1000,
  parameter int T_RSTD   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DW-1:0]     din,
  input  logic              din_vld,
  input  logic [GW-1:0]     din_grp,
  input  logic              din_fs,
  output logic [DW+GW-1:0]  m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              RST_A,
  output logic              RST_D,
  output logic              sensor_rdy,
  output logic [15:0]       ovf_cnt,
  output logic              err_short
);

  localparam int FW = DW + GW + 2;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [15:0] LAST = 16'(LINE_LEN - 1);

  typedef enum logic [1:0] {S_HOLD, S_AUP, S_RDY} seq_t;
  typedef enum logic {C_IDLE, C_LINE} cap_t;

  seq_t        seq_q, seq_d;
  logic [31:0] scnt_q, scnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q  <= S_HOLD;
      scnt_q <= '0;
    end else begin
      seq_q  <= seq_d;
      scnt_q <= scnt_d;
    end
  end

  always_comb begin
    seq_d  = seq_q;
    scnt_d = scnt_q + 32'd1;
    unique case (seq_q)
      S_HOLD: if (scnt_q == 32'(T_RSTA - 1)) begin
        seq_d  = S_AUP;
        scnt_d = '0;
      end
      S_AUP: if (scnt_q == 32'(T_RSTD - 1)) begin
        seq_d  = S_RDY;
        scnt_d = '0;
      end
      S_RDY: scnt_d = '0;
      default: begin
        seq_d  = S_HOLD;
        scnt_d = '0;
      end
    endcase
  end

  assign RST_A      = (seq_q != S_HOLD);
  assign RST_D      = (seq_q == S_RDY);
  assign sensor_rdy = (seq_q == S_RDY);

  cap_t        cap_q, cap_d;
  logic [15:0] pix_q, pix_d, idx;
  logic        wr_d, tuser_d, tlast_d, err_d;

  always_comb begin
    cap_d   = cap_q;
    pix_d   = pix_q;
    idx     = '0;
    wr_d    = 1'b0;
    tuser_d = 1'b0;
    tlast_d = 1'b0;
    err_d   = err_short;
    if (!(en && sensor_rdy)) begin
      cap_d = C_IDLE;
      pix_d = '0;
    end else if (din_vld) begin
      unique case (cap_q)
        C_IDLE: if (din_fs) begin
          wr_d    = 1'b1;
          tuser_d = 1'b1;
          cap_d   = C_LINE;
          pix_d   = 16'd1;
        end
        C_LINE: begin
          // a frame start always realigns the line to pixel 0
          idx     = din_fs ? '0 : pix_q;
          wr_d    = 1'b1;
          tuser_d = din_fs;
          tlast_d = (idx == LAST);
          pix_d   = tlast_d ? '0 : idx + 16'd1;
          if (din_fs && pix_q != '0) err_d = 1'b1;
        end
      endcase
    end
  end

  logic          wr_q;
  logic [FW-1:0] wbuf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q     <= C_IDLE;
      pix_q     <= '0;
      err_short <= 1'b0;
      wr_q      <= 1'b0;
      wbuf_q    <= '0;
    end else begin
      cap_q     <= cap_d;
      pix_q     <= pix_d;
      err_short <= err_d;
      wr_q      <= wr_d;
      wbuf_q    <= {tuser_d, tlast_d, din_grp, din};
    end
  end

  logic [FW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0]   fill;
  logic               push, pop;
  logic [FW-1:0]      head;

  // admission looks only at the registered level, never at a same-cycle pop
  assign push = wr_q && (fill < FULL);
  assign pop  = m_tvalid && m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      fill    <= '0;
      ovf_cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fill <= fill + {{FIFO_AW{1'b0}}, push}
                   - {{FIFO_AW{1'b0}}, pop};
      if (wr_q && !push && ovf_cnt != 16'hFFFF)
        ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wbuf_q;
  end

  assign head     = mem[rp];
  assign m_tvalid = (fill != '0);
  assign m_tdata  = m_tvalid ? head[DW+GW-1:0] : '0;
  assign m_tlast  = m_tvalid & head[FW-2];
  assign m_tuser  = m_tvalid & head[FW-1];

endmodule

// File: tb/tb_lvds_frame_rx.sv
// Bench for lvds_frame_rx: directed scenarios plus random traffic
// compared every cycle against a queue-level reference model.
module tb_lvds_frame_rx;

  localparam int DW = 15;
  localparam int GW = 1;
  localparam int L  = 4;
  localparam int AW = 2;
  localparam int TA = 10;
  localparam int TD = 5;
  localparam int DEPTH = 1 << AW;
  localparam int FW = DW + GW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [DW-1:0] din = '0;
  logic din_vld = 1'b0;
  logic [GW-1:0] din_grp = '0;
  logic din_fs = 1'b0;
  logic [DW+GW-1:0] m_tdata;
  logic m_tvalid;
  logic m_tready = 1'b0;
  logic m_tlast, m_tuser;
  logic RST_A, RST_D, sensor_rdy;
  logic [15:0] ovf_cnt;
  logic err_short;

  lvds_frame_rx #(
    .DW(DW), .GW(GW), .LINE_LEN(L), .FIFO_AW(AW),
    .T_RSTA(TA), .T_RSTD(TD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .din(din), .din_vld(din_vld), .din_grp(din_grp), .din_fs(din_fs),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .RST_A(RST_A), .RST_D(RST_D), .sensor_rdy(sensor_rdy),
    .ovf_cnt(ovf_cnt), .err_short(err_short)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, one pending word between capture
  // and FIFO admission, sequencer as a count of edges since release.
  logic [FW-1:0] mq[$];
  logic [FW-1:0] m_pw = '0;
  logic m_pv = 1'b0;
  logic m_line = 1'b0;
  int m_pos = 0;
  int m_cyc = 0;
  logic [15:0] m_ovf = '0;
  logic m_err = 1'b0;

  initial begin : model
    int fill;
    int idx;
    logic rdy;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_pv = 0; m_line = 0; m_pos = 0; m_cyc = 0;
        m_ovf = '0; m_err = 0;
      end else begin
        fill = mq.size();
        if (m_pv && fill >= DEPTH && m_ovf != 16'hFFFF) m_ovf++;
        if (fill != 0 && m_tready) mq.delete(0);
        if (m_pv && fill < DEPTH) mq.push_back(m_pw);
        m_pv = 0;
        rdy = (m_cyc >= TA + TD);
        if (!(en && rdy)) begin
          m_line = 0;
        end else if (din_vld) begin
          if (!m_line) begin
            if (din_fs) begin
              m_pw = {1'b1, 1'b0, din_grp, din};
              m_pv = 1; m_pos = 1; m_line = 1;
            end
          end else begin
            idx = din_fs ? 0 : m_pos;
            if (din_fs && m_pos != 0) m_err = 1;
            m_pw = {din_fs, idx == L - 1, din_grp, din};
            m_pv = 1;
            m_pos = (idx + 1) % L;
          end
        end
        m_cyc++;
      end
    end
  end

  logic [FW-1:0] beats[$];

  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      chk("tvalid", m_tvalid, mq.size() != 0);
      if (mq.size() != 0)
        chk("beat", {m_tuser, m_tlast, m_tdata}, mq[0]);
      chk("ovf_cnt", ovf_cnt, m_ovf);
      chk("err_short", err_short, m_err);
      chk("RST_A", RST_A, m_cyc >= TA);
      chk("RST_D", RST_D, m_cyc >= TA + TD);
      chk("sensor_rdy", sensor_rdy, m_cyc >= TA + TD);
      if (rst_n && m_tvalid && m_tready)
        beats.push_back({m_tuser, m_tlast, m_tdata});
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [GW-1:0] g,
                      input logic fs);
    din = d; din_grp = g; din_fs = fs; din_vld = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    din_vld = 1'b0; din_fs = 1'b0;
  endtask

  task automatic wait_seq();
    int n;
    n = 0;
    while (!RST_A && n < 100) begin @(negedge clk); n++; end
    chk("t_rsta", n, TA);
    n = 0;
    while (!RST_D && n < 100) begin @(negedge clk); n++; end
    chk("t_rstd", n, TD);
    chk("rdy_up", sensor_rdy, 1);
  endtask

  logic [DW+GW-1:0] sent[8];
  logic [7:0] tl, tu;

  initial begin : main
    repeat (3) @(negedge clk);
    chk("rst_RST_A", RST_A, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_ovf", ovf_cnt, 0);

    // traffic while the sensor is still in reset must be ignored
    en = 1; din_vld = 1; din_fs = 1; din = 15'h1234;
    rst_n = 1'b1;
    wait_seq();
    idle();
    chk("pre_rdy_tvalid", m_tvalid, 0);
    chk("pre_rdy_ovf", ovf_cnt, 0);

    for (int i = 0; i < 3; i++) send(DW'(i + 5), 1'b1, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    chk("no_fs_tvalid", m_tvalid, 0);
    en = 0;
    for (int i = 0; i < 2; i++) send(DW'(i + 9), 1'b0, 1'b1);
    idle();
    repeat (2) @(negedge clk);
    chk("en0_tvalid", m_tvalid, 0);
    chk("en0_ovf", ovf_cnt, 0);
    en = 1;

    // two full lines, streaming
    m_tready = 1;
    beats.delete();
    for (int i = 0; i < 8; i++) sent[i] = {1'(i), DW'(256 + i)};
    send(sent[0][DW-1:0], sent[0][DW+GW-1:DW], 1'b1);
    chk("lat_edge_n", m_tvalid, 0);
    send(sent[1][DW-1:0], sent[1][DW+GW-1:DW], 1'b0);
    chk("lat_edge_n1", m_tvalid, 1);
    chk("lat_tuser", m_tuser, 1);
    chk("lat_tdata", m_tdata, sent[0]);
    for (int i = 2; i < 8; i++)
      send(sent[i][DW-1:0], sent[i][DW+GW-1:DW], 1'b0);
    idle();
    repeat (4) @(negedge clk);
    chk("l8_count", beats.size(), 8);
    if (beats.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        tl[i] = beats[i][FW-2];
        tu[i] = beats[i][FW-1];
        chk("l8_data", beats[i][DW+GW-1:0], sent[i]);
      end
      chk("l8_tlast", tl, 8'b1000_1000);
      chk("l8_tuser", tu, 8'b0000_0001);
    end

    // overflow with a stalled sink
    m_tready = 0;
    beats.delete();
    for (int i = 0; i < 6; i++) begin
      sent[i] = {1'(i + 1), DW'(16'h0A00 + i)};
      send(sent[i][DW-1:0], sent[i][DW+GW-1:DW], i == 0);
    end
    idle();
    repeat (3) @(negedge clk);
    chk("ovf_two", ovf_cnt, 2);
    chk("ovf_no_err", err_short, 0);
    m_tready = 1;
    repeat (8) @(negedge clk);
    chk("ovf_drain_n", beats.size(), 4);
    if (beats.size() >= 4)
      for (int i = 0; i < 4; i++)
        chk("ovf_drain_d", beats[i][DW+GW-1:0], sent[i]);

    // line position is now 2: an early frame start is a short line
    beats.delete();
    send(15'h0777, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(DW'(i), 1'b0, 1'b0);
    idle();
    repeat (4) @(negedge clk);
    chk("short_err", err_short, 1);
    chk("short_n", beats.size(), 4);
    if (beats.size() >= 4) begin
      tl = '0; tu = '0;
      for (int i = 0; i < 4; i++) begin
        tl[i] = beats[i][FW-2];
        tu[i] = beats[i][FW-1];
      end
      chk("short_tuser", tu, 8'b0000_0001);
      chk("short_tlast", tl, 8'b0000_1000);
    end

    // reset with words buffered
    m_tready = 0;
    for (int i = 0; i < 3; i++) send(DW'(i + 40), 1'b1, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    chk("buf_tvalid", m_tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_tdata", m_tdata, 0);
    chk("mid_rst_tflags", {m_tlast, m_tuser}, 0);
    chk("mid_rst_ovf", ovf_cnt, 0);
    chk("mid_rst_err", err_short, 0);
    chk("mid_rst_seq", {RST_A, RST_D, sensor_rdy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_seq();

    // random traffic, one reset in the middle
    for (int c = 0; c < 2000; c++) begin
      en = ($urandom % 25) != 0;
      din_vld = ($urandom % 4) != 0;
      din_fs = ($urandom % 10) == 0;
      din = DW'($urandom);
      din_grp = GW'($urandom);
      m_tready = (c % 200 < 40) ? 1'b0 : (($urandom % 3) != 0);
      rst_n = !(c == 1000 || c == 1001);
      @(negedge clk);
    end
    idle();
    m_tready = 1;
    repeat (20) @(negedge clk);
    chk("final_empty", m_tvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lvds_frame_rx.md
LVDS_FRAME_RX -- requirements
Module: lvds_frame_rx

Interface
REQ-001 SHALL have parameter DW, default 15, pixel data width.
REQ-002 SHALL have parameter GW, default 1, data-group tag width.
REQ-003 SHALL have parameter LINE_LEN, default 640, pixels per line (2..65535).
REQ-004 SHALL have parameter FIFO_AW, default 4, log2 of output FIFO depth (DEPTH = 2^FIFO_AW).
REQ-005 SHALL have parameter T_RSTA, default 1000, clk cycles with RST_A and RST_D both low after reset.
REQ-006 SHALL have parameter T_RSTD, default 1000, clk cycles between RST_A rising and RST_D rising.
REQ-007 clk  input  1  module clock; single clock domain, rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 en  input  1  capture enable.
REQ-010 din  input  DW  deserialised pixel word, already synchronous to clk.
REQ-011 din_vld  input  1  din qualifier, one word per cycle when high.
REQ-012 din_grp  input  GW  group tag for din.
REQ-013 din_fs  input  1  frame start, qualified by din_vld.
REQ-014 m_tdata  output  DW+GW  {din_grp, din}.
REQ-015 m_tvalid / m_tready  output / input  1  AXI-Stream handshake.
REQ-016 m_tlast  output  1  last pixel of line.
REQ-017 m_tuser  output  1  first pixel of frame.
REQ-018 RST_A / RST_D  output  1  sensor analog / digital reset, active-low.
REQ-019 sensor_rdy  output  1  high when the reset sequence is complete.
REQ-020 ovf_cnt  output  16  dropped-word count.
REQ-021 err_short  output  1  sticky short-line flag.

Function
REQ-022 The sequencer SHALL run states S_HOLD -> S_AUP -> S_RDY.
REQ-023 S_HOLD: RST_A=0, RST_D=0 for exactly T_RSTA cycles after reset release, then S_AUP.
REQ-024 S_AUP: RST_A=1, RST_D=0 for exactly T_RSTD cycles, then S_RDY.
REQ-025 S_RDY: RST_A=1, RST_D=1, sensor_rdy=1; S_RDY SHALL be terminal until reset.
REQ-026 The capture FSM SHALL have states C_IDLE and C_LINE, and SHALL leave C_IDLE only when sensor_rdy=1 and en=1.
REQ-027 C_IDLE: din_vld=1 with din_fs=1 writes the word with tuser=1, sets pixel count to 1, and moves to C_LINE; other words are ignored and not counted.
REQ-028 C_LINE: each din_vld writes one word and increments the pixel count.
REQ-029 The word at count LINE_LEN-1 SHALL carry tlast=1; count then wraps to 0; state stays C_LINE.
REQ-030 din_fs=1 in C_LINE with count != 0 SHALL write the word with tuser=1, restart count at 1, and set err_short.
REQ-031 din_fs=1 in C_LINE with count == 0 SHALL be a normal frame start; err_short SHALL NOT be set.
REQ-032 Simultaneous tlast and tuser on one word SHALL be allowed when LINE_LEN=1 is not used; with LINE_LEN>=2 a single word SHALL never carry both.
REQ-033 en=0 SHALL force C_IDLE on the next cycle; the FIFO SHALL keep draining.
REQ-034 The FIFO SHALL be show-ahead with depth DEPTH, storing {tuser, tlast, grp, data}.
REQ-035 A write SHALL be accepted only if the registered fill level is < DEPTH, regardless of a same-cycle read.
REQ-036 A word rejected by a full FIFO SHALL be dropped; ovf_cnt SHALL increment, saturating at 16'hFFFF; the pixel count SHALL still advance so line alignment holds.
REQ-037 Latency: a word written at edge N into an empty FIFO SHALL present m_tvalid=1 after edge N+1.
REQ-038 m_tdata, m_tlast and m_tuser SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-039 A pop SHALL occur on m_tvalid & m_tready; with the FIFO empty, m_tvalid SHALL be 0.

Reset
REQ-040 rst_n low SHALL asynchronously force: RST_A=0, RST_D=0, sensor_rdy=0, S_HOLD, C_IDLE, FIFO empty, m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, ovf_cnt=0, err_short=0, pixel count 0.
REQ-041 Reset asserted mid-line or mid-sequence SHALL discard all FIFO contents and restart the sequencer from S_HOLD.

Verification
REQ-042 Reset release, T_RSTA=10, T_RSTD=5 -> RST_A rises 10 cycles after release, RST_D and sensor_rdy rise 5 cycles later.
REQ-043 LINE_LEN=4, m_tready=1, fs followed by 8 contiguous words -> 8 beats; tuser on beat 0; tlast on beats 3 and 7; first m_tvalid 1 cycle after the first write.
REQ-044 FIFO_AW=2, m_tready=0, 6 words -> 4 stored, ovf_cnt=2; then m_tready=1 -> the 4 words drain in order.
REQ-045 LINE_LEN=4, fs at count 2 -> err_short=1, that word has tuser=1, tlast appears 3 words later.
REQ-046 Words before the first fs, and words with en=0 or sensor_rdy=0 -> no FIFO writes, ovf_cnt unchanged.
REQ-047 rst_n pulsed low with 3 words buffered -> m_tvalid=0 immediately, all outputs at reset values, sequencer restarts.
